// File: rtl/axis_dma_read_wqe_arb_mux.sv
// DMA read descriptor arbiter/mux with per-channel outstanding limits and completion demux.
// Build option: define AXIS_DMA_READ_WQE_ARB_MUX_RR_EN for round-robin, otherwise fixed priority (highest index wins).
`timescale 1ns/1ps
module axis_dma_read_wqe_arb_mux #(
  parameter int PORTS           = 2,
  parameter int DMA_ADDR_WIDTH  = 64,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int DMA_LEN_WIDTH   = 20,
  parameter int DMA_TAG_WIDTH   = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CL_PORTS       = $clog2(PORTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS*DMA_ADDR_WIDTH-1:0]     s_axis_desc_dma_addr,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]     s_axis_desc_ram_addr,
  input  logic [PORTS*DMA_LEN_WIDTH-1:0]      s_axis_desc_len,
  input  logic [PORTS*DMA_TAG_WIDTH-1:0]      s_axis_desc_tag,
  input  logic [PORTS-1:0]                    s_axis_desc_valid,
  output logic [PORTS-1:0]                    s_axis_desc_ready,
  output logic [DMA_ADDR_WIDTH-1:0]           m_axis_desc_dma_addr,
  output logic [RAM_ADDR_WIDTH-1:0]           m_axis_desc_ram_addr,
  output logic [DMA_LEN_WIDTH-1:0]            m_axis_desc_len,
  output logic [DMA_TAG_WIDTH+CL_PORTS-1:0]   m_axis_desc_tag,
  output logic                                m_axis_desc_valid,
  input  logic                                m_axis_desc_ready,
  input  logic [DMA_TAG_WIDTH+CL_PORTS-1:0]   s_axis_status_tag,
  input  logic                                s_axis_status_valid,
  output logic [PORTS*DMA_TAG_WIDTH-1:0]      m_axis_status_tag,
  output logic [PORTS-1:0]                    m_axis_status_valid
);

  localparam int         OUT_TAG_W = DMA_TAG_WIDTH + CL_PORTS;
  localparam logic [7:0] MAX_CNT   = 8'(MAX_OUTSTANDING);

  logic [DMA_ADDR_WIDTH-1:0] dma_addr_arr [PORTS];
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_arr [PORTS];
  logic [DMA_LEN_WIDTH-1:0]  len_arr      [PORTS];
  logic [DMA_TAG_WIDTH-1:0]  tag_arr      [PORTS];
  logic [7:0]                cnt_reg      [PORTS];
  logic [7:0]                cnt_next     [PORTS];

  logic [PORTS-1:0]    eligible;
  logic [PORTS-1:0]    cnt_inc;
  logic [PORTS-1:0]    cnt_dec;
  logic                grant_valid;
  logic [CL_PORTS-1:0] gnt_idx;

  logic [DMA_ADDR_WIDTH-1:0] desc_dma_addr_reg;
  logic [RAM_ADDR_WIDTH-1:0] desc_ram_addr_reg;
  logic [DMA_LEN_WIDTH-1:0]  desc_len_reg;
  logic [OUT_TAG_W-1:0]      desc_tag_reg;
  logic                      desc_valid_reg;

  logic [PORTS-1:0]               status_valid_reg;
  logic [PORTS*DMA_TAG_WIDTH-1:0] status_tag_reg;

  logic [CL_PORTS-1:0] st_ch;
  logic                st_hit;

  // Status channel field sits in the tag MSBs; codes beyond PORTS-1 are dropped.
  assign st_ch       = s_axis_status_tag[OUT_TAG_W-1 -: CL_PORTS];
  assign st_hit      = s_axis_status_valid && (int'(st_ch) < PORTS);
  assign grant_valid = (!desc_valid_reg || m_axis_desc_ready) && (|eligible);

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_ch
      assign dma_addr_arr[gi] = s_axis_desc_dma_addr[gi*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
      assign ram_addr_arr[gi] = s_axis_desc_ram_addr[gi*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      assign len_arr[gi]      = s_axis_desc_len[gi*DMA_LEN_WIDTH +: DMA_LEN_WIDTH];
      assign tag_arr[gi]      = s_axis_desc_tag[gi*DMA_TAG_WIDTH +: DMA_TAG_WIDTH];

      assign eligible[gi]          = s_axis_desc_valid[gi] && (cnt_reg[gi] < MAX_CNT);
      assign cnt_inc[gi]           = grant_valid && (gnt_idx == CL_PORTS'(gi));
      assign cnt_dec[gi]           = st_hit && (st_ch == CL_PORTS'(gi));
      assign s_axis_desc_ready[gi] = cnt_inc[gi];

      // Grant and completion in the same cycle cancel; a stray completion never underflows.
      assign cnt_next[gi] = (cnt_inc[gi] && !cnt_dec[gi]) ? cnt_reg[gi] + 8'd1 :
                            (cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg[gi] != 8'd0)) ? cnt_reg[gi] - 8'd1 :
                            cnt_reg[gi];
    end
  endgenerate

`ifdef AXIS_DMA_READ_WQE_ARB_MUX_RR_EN
  logic [CL_PORTS-1:0] rr_ptr_reg;
  logic [CL_PORTS-1:0] rr_ptr_next;
  logic [CL_PORTS-1:0] rr_idx;
  logic                rr_found;
  int                  rr_sum;

  // rr_ptr_reg is the first index searched, i.e. one past the last grant.
  always_comb begin
    gnt_idx  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = 0;
    for (int k = 0; k < PORTS; k++) begin
      rr_sum = int'(rr_ptr_reg) + k;
      if (rr_sum >= PORTS) rr_sum = rr_sum - PORTS;
      rr_idx = CL_PORTS'(rr_sum);
      if (!rr_found && eligible[rr_idx]) begin
        rr_found = 1'b1;
        gnt_idx  = rr_idx;
      end
    end
  end

  assign rr_ptr_next = (int'(gnt_idx) == PORTS - 1) ? '0 : gnt_idx + CL_PORTS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (eligible[i]) gnt_idx = CL_PORTS'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++) cnt_reg[i] <= 8'd0;
    end else begin
      for (int i = 0; i < PORTS; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // Single output slot: reloads on the same cycle it is drained, giving one descriptor per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_dma_addr_reg <= '0;
      desc_ram_addr_reg <= '0;
      desc_len_reg      <= '0;
      desc_tag_reg      <= '0;
      desc_valid_reg    <= 1'b0;
    end else if (grant_valid) begin
      desc_dma_addr_reg <= dma_addr_arr[gnt_idx];
      desc_ram_addr_reg <= ram_addr_arr[gnt_idx];
      desc_len_reg      <= len_arr[gnt_idx];
      desc_tag_reg      <= {gnt_idx, tag_arr[gnt_idx]};
      desc_valid_reg    <= 1'b1;
    end else if (m_axis_desc_ready) begin
      desc_valid_reg    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_valid_reg <= '0;
      status_tag_reg   <= '0;
    end else begin
      status_valid_reg <= cnt_dec;
      for (int i = 0; i < PORTS; i++) begin
        if (cnt_dec[i]) begin
          status_tag_reg[i*DMA_TAG_WIDTH +: DMA_TAG_WIDTH] <= s_axis_status_tag[DMA_TAG_WIDTH-1:0];
        end
      end
    end
  end

  assign m_axis_desc_dma_addr = desc_dma_addr_reg;
  assign m_axis_desc_ram_addr = desc_ram_addr_reg;
  assign m_axis_desc_len      = desc_len_reg;
  assign m_axis_desc_tag      = desc_tag_reg;
  assign m_axis_desc_valid    = desc_valid_reg;
  assign m_axis_status_tag    = status_tag_reg;
  assign m_axis_status_valid  = status_valid_reg;

endmodule

// File: tb/tb_axis_dma_read_wqe_arb_mux.sv
// Bench: directed steps on a 2-port instance, then a randomized run of a 3-port instance (limit 2) against a queue-free model.
`timescale 1ns/1ps
module tb_axis_dma_read_wqe_arb_mux;

`ifdef AXIS_DMA_READ_WQE_ARB_MUX_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk;
  logic rst;

  logic [127:0] a_dma;
  logic [31:0]  a_ram;
  logic [39:0]  a_len;
  logic [31:0]  a_tag;
  logic [1:0]   a_valid, a_ready;
  logic [63:0]  a_m_dma;
  logic [15:0]  a_m_ram;
  logic [19:0]  a_m_len;
  logic [16:0]  a_m_tag;
  logic         a_m_valid, a_m_ready;
  logic [16:0]  a_st_tag;
  logic         a_st_valid;
  logic [31:0]  a_ms_tag;
  logic [1:0]   a_ms_valid;

  logic [191:0] b_dma;
  logic [47:0]  b_ram;
  logic [59:0]  b_len;
  logic [47:0]  b_tag;
  logic [2:0]   b_valid, b_ready;
  logic [63:0]  b_m_dma;
  logic [15:0]  b_m_ram;
  logic [19:0]  b_m_len;
  logic [17:0]  b_m_tag;
  logic         b_m_valid, b_m_ready;
  logic [17:0]  b_st_tag;
  logic         b_st_valid;
  logic [47:0]  b_ms_tag;
  logic [2:0]   b_ms_valid;

  axis_dma_read_wqe_arb_mux #(.PORTS(2)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_desc_dma_addr(a_dma), .s_axis_desc_ram_addr(a_ram),
    .s_axis_desc_len(a_len), .s_axis_desc_tag(a_tag),
    .s_axis_desc_valid(a_valid), .s_axis_desc_ready(a_ready),
    .m_axis_desc_dma_addr(a_m_dma), .m_axis_desc_ram_addr(a_m_ram),
    .m_axis_desc_len(a_m_len), .m_axis_desc_tag(a_m_tag),
    .m_axis_desc_valid(a_m_valid), .m_axis_desc_ready(a_m_ready),
    .s_axis_status_tag(a_st_tag), .s_axis_status_valid(a_st_valid),
    .m_axis_status_tag(a_ms_tag), .m_axis_status_valid(a_ms_valid)
  );

  axis_dma_read_wqe_arb_mux #(.PORTS(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_desc_dma_addr(b_dma), .s_axis_desc_ram_addr(b_ram),
    .s_axis_desc_len(b_len), .s_axis_desc_tag(b_tag),
    .s_axis_desc_valid(b_valid), .s_axis_desc_ready(b_ready),
    .m_axis_desc_dma_addr(b_m_dma), .m_axis_desc_ram_addr(b_m_ram),
    .m_axis_desc_len(b_m_len), .m_axis_desc_tag(b_m_tag),
    .m_axis_desc_valid(b_m_valid), .m_axis_desc_ready(b_m_ready),
    .s_axis_status_tag(b_st_tag), .s_axis_status_valid(b_st_valid),
    .m_axis_status_tag(b_ms_tag), .m_axis_status_valid(b_ms_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state for dut_b
  int          mdl_out [3];
  bit          mdl_slot_v;
  logic [63:0] mdl_dma;
  logic [15:0] mdl_ram;
  logic [19:0] mdl_len;
  logic [17:0] mdl_tag;
  logic [2:0]  mdl_st_v;
  logic [47:0] mdl_st_tag;
  int          mdl_ptr;
  int          pick, c, st_ch, exp_ch;
  bit          inc, dec;

  initial begin
    rst = 1'b1;
    a_dma = '0; a_ram = '0; a_len = '0; a_tag = '0; a_valid = '0; a_m_ready = 1'b0;
    a_st_tag = '0; a_st_valid = 1'b0;
    b_dma = '0; b_ram = '0; b_len = '0; b_tag = '0; b_valid = '0; b_m_ready = 1'b0;
    b_st_tag = '0; b_st_valid = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_m_valid", a_m_valid, 1'b0);
    chk("rst_a_ms_valid", a_ms_valid, 2'b00);
    chk("rst_a_m_dma", a_m_dma, 64'h0);
    chk("rst_a_m_tag", a_m_tag, 17'h0);
    chk("rst_b_m_valid", b_m_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Both channels valid, sink always ready
    a_dma = {64'h00B1, 64'h00A0};
    a_tag = {16'h0022, 16'h0011};
    a_ram = {16'h0201, 16'h0200};
    a_len = {20'h00101, 20'h00100};
    a_valid = 2'b11;
    a_m_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_ch = RR_MODE ? (n % 2) : 1;
      #1;
      chk("a_prio_ready", a_ready, (exp_ch == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      chk("a_prio_valid", a_m_valid, 1'b1);
      chk("a_prio_tag", a_m_tag, {1'(exp_ch), (exp_ch == 1) ? 16'h0022 : 16'h0011});
      chk("a_prio_dma", a_m_dma, (exp_ch == 1) ? 64'h00B1 : 64'h00A0);
      @(negedge clk);
    end

    // Drain the slot
    a_valid = 2'b00;
    #1;
    chk("a_drain_ready", a_ready, 2'b00);
    @(posedge clk); #1;
    chk("a_drain_valid", a_m_valid, 1'b0);
    @(negedge clk);

    // Back-pressure: payload holds, no second grant
    a_valid = 2'b01;
    a_dma[63:0] = 64'h1000;
    a_m_ready = 1'b0;
    #1;
    chk("a_bp_first_ready", a_ready, 2'b01);
    @(posedge clk); #1;
    chk("a_bp_first_dma", a_m_dma, 64'h1000);
    @(negedge clk);
    a_dma[63:0] = 64'h2000;
    repeat (5) begin
      #1;
      chk("a_bp_ready", a_ready, 2'b00);
      @(posedge clk); #1;
      chk("a_bp_valid", a_m_valid, 1'b1);
      chk("a_bp_dma", a_m_dma, 64'h1000);
      @(negedge clk);
    end
    a_valid = 2'b00;
    a_m_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_bp_release_valid", a_m_valid, 1'b0);
    @(negedge clk);

    // Status demux to channel 1
    a_st_tag = {1'b1, 16'h00AB};
    a_st_valid = 1'b1;
    @(posedge clk); #1;
    chk("a_status_valid", a_ms_valid, 2'b10);
    chk("a_status_tag1", a_ms_tag[31:16], 16'h00AB);
    @(negedge clk);
    a_st_valid = 1'b0;
    @(posedge clk); #1;
    chk("a_status_pulse_end", a_ms_valid, 2'b00);
    @(negedge clk);

    // Outstanding limit on dut_b channel 0
    b_valid = 3'b001;
    b_dma[63:0] = 64'h3000;
    b_m_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("b_fill_ready", b_ready, 3'b001);
      @(negedge clk);
    end
    b_st_tag = {2'd0, 16'h1234};
    b_st_valid = 1'b1;
    #1;
    chk("b_limit_ready", b_ready, 3'b000);
    @(posedge clk); #1;
    chk("b_status_valid", b_ms_valid, 3'b001);
    @(negedge clk);
    b_st_valid = 1'b0;
    #1;
    chk("b_resume_ready", b_ready, 3'b001);
    @(negedge clk);
    b_st_tag = {2'd3, 16'h0055};
    b_st_valid = 1'b1;
    #1;
    chk("b_relimit_ready", b_ready, 3'b000);
    @(posedge clk); #1;
    chk("b_oor_status_valid", b_ms_valid, 3'b000);
    chk("b_oor_status_tag", b_ms_tag, 48'h1234);
    @(negedge clk);
    b_st_valid = 1'b0;
    #1;
    chk("b_oor_nodec_ready", b_ready, 3'b000);

    // Reset in the middle of a burst
    a_valid = 2'b11;
    a_st_tag = {1'b0, 16'h0077};
    a_st_valid = 1'b1;
    @(posedge clk); #1;
    chk("a_burst_valid", a_m_valid, 1'b1);
    chk("a_burst_status", a_ms_valid, 2'b01);
    rst = 1'b1;
    #1;
    chk("rst_async_a_valid", a_m_valid, 1'b0);
    chk("rst_async_a_status", a_ms_valid, 2'b00);
    chk("rst_async_a_dma", a_m_dma, 64'h0);
    chk("rst_async_b_valid", b_m_valid, 1'b0);
    @(negedge clk);
    a_valid = 2'b00;
    a_st_valid = 1'b0;
    b_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    b_valid = 3'b001;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("b_post_rst_ready", b_ready, 3'b001);
      @(negedge clk);
    end
    #1;
    chk("b_post_rst_limit", b_ready, 3'b000);
    @(negedge clk);

    // Randomized run of dut_b against the model
    b_valid = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mdl_out[i] = 0;
    mdl_slot_v = 1'b0;
    mdl_dma = '0; mdl_ram = '0; mdl_len = '0; mdl_tag = '0;
    mdl_st_v = '0;
    mdl_st_tag = '0;
    mdl_ptr = 0;

    for (int n = 0; n < 400; n++) begin
      b_valid = (n < 4) ? 3'b111 : 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        b_dma[k*64 +: 64] = {$urandom, $urandom};
        b_ram[k*16 +: 16] = 16'($urandom);
        b_len[k*20 +: 20] = 20'($urandom);
        b_tag[k*16 +: 16] = 16'($urandom);
      end
      b_m_ready = (n < 4) || ($urandom_range(0, 3) != 0);
      b_st_valid = (n >= 4) && ($urandom_range(0, 2) == 0);
      b_st_tag = 18'($urandom);
      #1;

      pick = -1;
      if (!mdl_slot_v || b_m_ready) begin
`ifdef AXIS_DMA_READ_WQE_ARB_MUX_RR_EN
        for (int k = 0; k < 3; k++) begin
          c = (mdl_ptr + k) % 3;
          if (pick < 0 && b_valid[c] && mdl_out[c] < 2) pick = c;
        end
`else
        for (int k = 0; k < 3; k++) begin
          if (b_valid[k] && mdl_out[k] < 2) pick = k;
        end
`endif
      end
      chk("rand_desc_ready", b_ready, (pick >= 0) ? (128'd1 << pick) : 128'd0);

      if (pick >= 0) begin
        mdl_dma = b_dma[pick*64 +: 64];
        mdl_ram = b_ram[pick*16 +: 16];
        mdl_len = b_len[pick*20 +: 20];
        mdl_tag = {2'(pick), b_tag[pick*16 +: 16]};
        mdl_slot_v = 1'b1;
        mdl_ptr = (pick + 1) % 3;
      end else if (b_m_ready) begin
        mdl_slot_v = 1'b0;
      end
      st_ch = int'(b_st_tag[17:16]);
      mdl_st_v = '0;
      if (b_st_valid && st_ch < 3) begin
        mdl_st_v[st_ch] = 1'b1;
        mdl_st_tag[st_ch*16 +: 16] = b_st_tag[15:0];
      end
      for (int k = 0; k < 3; k++) begin
        inc = (pick == k);
        dec = b_st_valid && (st_ch == k);
        if (inc && !dec) mdl_out[k] = mdl_out[k] + 1;
        else if (dec && !inc && mdl_out[k] > 0) mdl_out[k] = mdl_out[k] - 1;
      end

      @(posedge clk); #1;
      chk("rand_m_valid", b_m_valid, mdl_slot_v);
      if (mdl_slot_v) begin
        chk("rand_m_dma", b_m_dma, mdl_dma);
        chk("rand_m_ram", b_m_ram, mdl_ram);
        chk("rand_m_len", b_m_len, mdl_len);
        chk("rand_m_tag", b_m_tag, mdl_tag);
      end
      chk("rand_status_valid", b_ms_valid, mdl_st_v);
      chk("rand_status_tag", b_ms_tag, mdl_st_tag);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_dma_read_wqe_arb_mux.md
AXIS_DMA_READ_WQE_ARB_MUX -- requirements
Module: axis_dma_read_wqe_arb_mux

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of requesting channels, 2..16.
REQ-002 SHALL have parameter DMA_ADDR_WIDTH, default 64: host DMA address width.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 16: local RAM address width.
REQ-004 SHALL have parameter DMA_LEN_WIDTH, default 20: transfer length width.
REQ-005 SHALL have parameter DMA_TAG_WIDTH, default 16: per-channel tag width.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 8: per-channel in-flight descriptor limit, 1..255.
REQ-007 SHALL derive CL_PORTS = $clog2(PORTS), not user-set.
REQ-008 SHALL have port clk, input, 1: sole clock.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port s_axis_desc_dma_addr, input, PORTS*DMA_ADDR_WIDTH: per-channel DMA address, channel i at slice i.
REQ-011 SHALL have port s_axis_desc_ram_addr, input, PORTS*RAM_ADDR_WIDTH: per-channel RAM address.
REQ-012 SHALL have port s_axis_desc_len, input, PORTS*DMA_LEN_WIDTH: per-channel length.
REQ-013 SHALL have port s_axis_desc_tag, input, PORTS*DMA_TAG_WIDTH: per-channel tag.
REQ-014 SHALL have ports s_axis_desc_valid, input, PORTS, and s_axis_desc_ready, output, PORTS: per-channel handshake.
REQ-015 SHALL have ports m_axis_desc_dma_addr, m_axis_desc_ram_addr, m_axis_desc_len, outputs, matching widths: merged descriptor.
REQ-016 SHALL have port m_axis_desc_tag, output, DMA_TAG_WIDTH+CL_PORTS: {channel index, channel tag}.
REQ-017 SHALL have ports m_axis_desc_valid, output, 1, and m_axis_desc_ready, input, 1.
REQ-018 SHALL have ports s_axis_status_tag, input, DMA_TAG_WIDTH+CL_PORTS, and s_axis_status_valid, input, 1: DMA completion (no ready).
REQ-019 SHALL have ports m_axis_status_tag, output, PORTS*DMA_TAG_WIDTH, and m_axis_status_valid, output, PORTS: demuxed completion.

Function
REQ-020 SHALL treat channel i as eligible when s_axis_desc_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-021 SHALL hold one registered output slot; a grant occurs when any channel is eligible and the slot is empty or m_axis_desc_ready=1 that cycle.
REQ-022 SHALL assert s_axis_desc_ready only for the granted channel, combinationally, at most one bit set.
REQ-023 SHALL present the granted descriptor on m_axis_desc_* the cycle after grant (latency 1); valid holds with stable payload until m_axis_desc_ready=1.
REQ-024 SHALL sustain one descriptor per cycle while m_axis_desc_ready=1.
REQ-025 SHALL increment outstanding[i] on grant of channel i, decrement on status with tag MSBs = i; both same cycle leaves it unchanged.
REQ-026 SHALL, on status for a channel with outstanding=0, keep the counter at 0 and still forward the status.
REQ-027 SHALL ignore status whose channel field >= PORTS (no counter change, no output pulse).
REQ-028 SHALL register status: m_axis_status_valid[i] pulses one cycle, one cycle after s_axis_status_valid, with tag LSBs on slice i.

Reset
REQ-029 SHALL, on rst, asynchronously clear m_axis_desc_valid, m_axis_status_valid, all outstanding counters and the arbitration pointer; data outputs reset to 0.
REQ-030 SHALL drop an unaccepted output descriptor on mid-operation reset; the counter is not restored.

Configuration
REQ-031 SHALL, with AXIS_DMA_READ_WQE_ARB_MUX_RR_EN defined, arbitrate round-robin: search starts at index after last granted, wrapping PORTS-1 to 0.
REQ-032 SHALL, without AXIS_DMA_READ_WQE_ARB_MUX_RR_EN, arbitrate fixed priority, highest index wins.

Verification
REQ-033 SHALL test PORTS=2, both valid, ready=1, fixed priority -> channel 1 output every cycle, tag MSB=1; channel 0 stalled.
REQ-034 SHALL test RR build, PORTS=4, all valid, ready=1 -> grant order 0,1,2,3,0 with pointer reset to 0.
REQ-035 SHALL test MAX_OUTSTANDING=2, channel 0 issues 2 with no status -> s_axis_desc_ready[0]=0; status tag {0,x} -> grant resumes next cycle.
REQ-036 SHALL test m_axis_desc_ready=0 for 5 cycles with descriptor addr 0x1000 -> payload stable, no second grant.
REQ-037 SHALL test status tag {1,0x00AB} -> m_axis_status_valid=2'b10 one cycle later, slice 1 = 0x00AB.
REQ-038 SHALL test rst asserted mid-burst -> valid outputs 0 immediately, counters 0.
